// File: rtl/mips_mc_controller.sv
// Multi-cycle control unit for a MIPS core sharing one memory between instruction fetch and
// data access. Sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes and
// selects for each cycle. It also counts retired instructions.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   opcode_i, funct_i     IR[31:26] and IR[5:0] (valid from DECODE onwards)
//   zero_i, positive_i    ALU result == 0, rs > 0 (sampled in EXEC for branches)
//   overflow_i            signed overflow of the EXEC operation
//   mem_ready_i           memory access completes this cycle
//   mem_req_o, mem_iord_o, mem_write_o    memory strobe, address select, store strobe
//   ir_write_o, pc_write_o, npc_sel_o     IR load, PC load, next-PC select
//   alu_ctl_o, alu_src_o, ext_op_o        ALU operation, operand-B select, imm extension
//   reg_dst_o, reg_src_o, reg_write_o     register-file destination, source, write strobe
//   illegal_o             one-cycle pulse in DECODE for an undecodable instruction
//   instret_o             retired-instruction count
//   state_o               current state (debug)
module mips_mc_controller #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             positive_i,
  input  logic             overflow_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_iord_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       npc_sel_o,
  output logic [1:0]       alu_ctl_o,
  output logic             alu_src_o,
  output logic             ext_op_o,
  output logic [1:0]       reg_dst_o,
  output logic [2:0]       reg_src_o,
  output logic             reg_write_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    InsAddu, InsSubu, InsJr, InsAddi, InsOri, InsLui, InsLw, InsSw,
    InsBeq, InsBgtz, InsJ, InsJal, InsIllegal
  } insn_e;

  state_e            state_q, state_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  instret_q;
  insn_e             insn;
  logic              mem_done;
  logic              retire;

  assign mem_done  = !MEM_WAIT_EN || mem_ready_i;
  assign instret_o = instret_q;
  assign state_o   = state_q;

  // Instruction decode from the IR fields.
  always_comb begin
    insn = InsIllegal;
    case (opcode_i)
      6'h00: begin
        case (funct_i)
          6'h21:   insn = InsAddu;
          6'h23:   insn = InsSubu;
          6'h08:   insn = InsJr;
          default: insn = InsIllegal;
        endcase
      end
      6'h08:   insn = InsAddi;
      6'h0D:   insn = InsOri;
      6'h0F:   insn = InsLui;
      6'h23:   insn = InsLw;
      6'h2B:   insn = InsSw;
      6'h04:   insn = InsBeq;
      6'h07:   insn = InsBgtz;
      6'h02:   insn = InsJ;
      6'h03:   insn = InsJal;
      default: insn = InsIllegal;
    endcase
  end

  // Next-state and per-cycle control outputs.
  always_comb begin
    state_d     = state_q;
    ovf_d       = ovf_q;
    retire      = 1'b0;
    mem_req_o   = 1'b0;
    mem_iord_o  = 1'b0;
    mem_write_o = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    npc_sel_o   = 2'd0;
    alu_ctl_o   = 2'd0;
    alu_src_o   = 1'b0;
    ext_op_o    = 1'b0;
    reg_dst_o   = 2'd0;
    reg_src_o   = 3'd0;
    reg_write_o = 1'b0;
    illegal_o   = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req_o = 1'b1;
        if (mem_done) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = StDecode;
        end
      end

      StDecode: begin
        state_d = StExec;
        case (insn)
          InsJ: begin
            pc_write_o = 1'b1;
            npc_sel_o  = 2'd2;
            state_d    = StFetch;
            retire     = 1'b1;
          end
          InsJal: begin
            pc_write_o  = 1'b1;
            npc_sel_o   = 2'd2;
            reg_write_o = 1'b1;
            reg_dst_o   = 2'd2;
            reg_src_o   = 3'd2;
            state_d     = StFetch;
            retire      = 1'b1;
          end
          InsJr: begin
            pc_write_o = 1'b1;
            npc_sel_o  = 2'd3;
            state_d    = StFetch;
            retire     = 1'b1;
          end
          InsIllegal: begin
            // Dropped without retiring.
            illegal_o = 1'b1;
            state_d   = StFetch;
          end
          default: state_d = StExec;
        endcase
      end

      StExec: begin
        // Overflow only matters in WB, by which time the ALU inputs may have moved on.
        ovf_d = overflow_i;
        case (insn)
          InsAddu: begin
            state_d = StWb;
          end
          InsSubu: begin
            alu_ctl_o = 2'd1;
            state_d   = StWb;
          end
          InsAddi: begin
            alu_src_o = 1'b1;
            ext_op_o  = 1'b1;
            state_d   = StWb;
          end
          InsOri: begin
            alu_ctl_o = 2'd2;
            alu_src_o = 1'b1;
            state_d   = StWb;
          end
          InsLui: begin
            alu_ctl_o = 2'd3;
            alu_src_o = 1'b1;
            state_d   = StWb;
          end
          InsLw, InsSw: begin
            alu_src_o = 1'b1;
            ext_op_o  = 1'b1;
            state_d   = StMem;
          end
          InsBeq, InsBgtz: begin
            alu_ctl_o = 2'd1;
            ext_op_o  = 1'b1;
            if ((insn == InsBeq) ? zero_i : positive_i) begin
              pc_write_o = 1'b1;
              npc_sel_o  = 2'd1;
            end
            state_d = StFetch;
            retire  = 1'b1;
          end
          default: begin
            state_d = StFetch;
          end
        endcase
      end

      StMem: begin
        mem_req_o   = 1'b1;
        mem_iord_o  = 1'b1;
        mem_write_o = (insn == InsSw);
        if (mem_done) begin
          if (insn == InsLw) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end
      end

      StWb: begin
        reg_write_o = !((insn == InsAddi) && ovf_q);
        reg_dst_o   = (insn == InsAddu || insn == InsSubu) ? 2'd1 : 2'd0;
        reg_src_o   = (insn == InsLw) ? 3'd1 : 3'd0;
        state_d     = StFetch;
        retire      = 1'b1;
      end

      default: begin
        state_d = StFetch;
      end
    endcase

    // Reset abandons any access in flight: nothing is written in a reset cycle.
    if (rst_i) begin
      retire      = 1'b0;
      mem_req_o   = 1'b0;
      mem_iord_o  = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      npc_sel_o   = 2'd0;
      alu_ctl_o   = 2'd0;
      alu_src_o   = 1'b0;
      ext_op_o    = 1'b0;
      reg_dst_o   = 2'd0;
      reg_src_o   = 3'd0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      ovf_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller. Two instances: d0 with MEM_WAIT_EN=0 and a 4-bit counter
// (exercises wrap), d1 with MEM_WAIT_EN=1. Only one runs at a time; the other is held in
// reset and must keep its strobes low. Each instruction is expanded into its list of
// expected phases and the per-cycle controls are derived from the instruction class.
module tb_mips_mc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [5:0] opcode, funct;
  logic       zero, positive, overflow, mem_ready;

  logic [1:0]      mem_req, mem_iord, mem_write, ir_write, pc_write, alu_src, ext_op;
  logic [1:0]      reg_write, illegal;
  logic [1:0][1:0] npc_sel, alu_ctl, reg_dst;
  logic [1:0][2:0] reg_src, state;
  logic [3:0]      instret0;
  logic [31:0]     instret1;

  mips_mc_controller #(.MEM_WAIT_EN(1'b0), .CNT_W(4)) u_d0 (
    .clk_i(clk), .rst_i(rst0), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .positive_i(positive), .overflow_i(overflow), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req[0]), .mem_iord_o(mem_iord[0]), .mem_write_o(mem_write[0]),
    .ir_write_o(ir_write[0]), .pc_write_o(pc_write[0]), .npc_sel_o(npc_sel[0]),
    .alu_ctl_o(alu_ctl[0]), .alu_src_o(alu_src[0]), .ext_op_o(ext_op[0]),
    .reg_dst_o(reg_dst[0]), .reg_src_o(reg_src[0]), .reg_write_o(reg_write[0]),
    .illegal_o(illegal[0]), .instret_o(instret0), .state_o(state[0])
  );

  mips_mc_controller #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) u_d1 (
    .clk_i(clk), .rst_i(rst1), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .positive_i(positive), .overflow_i(overflow), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req[1]), .mem_iord_o(mem_iord[1]), .mem_write_o(mem_write[1]),
    .ir_write_o(ir_write[1]), .pc_write_o(pc_write[1]), .npc_sel_o(npc_sel[1]),
    .alu_ctl_o(alu_ctl[1]), .alu_src_o(alu_src[1]), .ext_op_o(ext_op[1]),
    .reg_dst_o(reg_dst[1]), .reg_src_o(reg_src[1]), .reg_write_o(reg_write[1]),
    .illegal_o(illegal[1]), .instret_o(instret1), .state_o(state[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction classes.
  localparam int CAddu = 0, CSubu = 1, CAddi = 2, COri = 3, CLui = 4, CLw = 5, CSw = 6;
  localparam int CBeq = 7, CBgtz = 8, CJ = 9, CJal = 10, CJr = 11, CIll = 12;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h21) return CAddu;
      if (fn == 6'h23) return CSubu;
      if (fn == 6'h08) return CJr;
      return CIll;
    end
    case (op)
      6'h08: return CAddi;
      6'h0D: return COri;
      6'h0F: return CLui;
      6'h23: return CLw;
      6'h2B: return CSw;
      6'h04: return CBeq;
      6'h07: return CBgtz;
      6'h02: return CJ;
      6'h03: return CJal;
      default: return CIll;
    endcase
  endfunction

  // {mem_req, mem_write, ir_write, pc_write, reg_write, illegal}
  function automatic logic [5:0] strobes(input int d);
    return {mem_req[d], mem_write[d], ir_write[d], pc_write[d], reg_write[d], illegal[d]};
  endfunction

  function automatic logic [31:0] instret_of(input int d);
    return (d == 0) ? {28'd0, instret0} : instret1;
  endfunction

  typedef struct {
    int st;
    bit last;
  } ph_t;

  int unsigned cnt[2];
  bit          fix_flags = 1'b0;
  bit          fix_val   = 1'b0;

  // Runs one instruction on DUT d. wf/wm: memory wait cycles in FETCH/MEM.
  // rst_at >= 0 asserts reset on that phase index and abandons the instruction.
  task automatic run_insn(input int d, input logic [5:0] op, input logic [5:0] fn,
                          input int wf, input int wm, input int rst_at);
    ph_t q[$];
    int  c;
    bit  ovf_s;
    logic [5:0] es;
    logic [1:0] enpc, edst;
    logic [2:0] esrc;
    c = classify(op, fn);
    ovf_s = 1'b0;
    for (int i = 0; i <= wf; i++) q.push_back('{0, i == wf});
    q.push_back('{1, 1'b1});
    if (c <= CLui) begin
      q.push_back('{2, 1'b1});
      q.push_back('{4, 1'b1});
    end else if (c == CLw || c == CSw) begin
      q.push_back('{2, 1'b1});
      for (int i = 0; i <= wm; i++) q.push_back('{3, i == wm});
      if (c == CLw) q.push_back('{4, 1'b1});
    end else if (c == CBeq || c == CBgtz) begin
      q.push_back('{2, 1'b1});
    end

    opcode = op;
    funct  = fn;
    for (int i = 0; i < q.size(); i++) begin
      zero      = fix_flags ? fix_val : 1'($urandom);
      positive  = fix_flags ? fix_val : 1'($urandom);
      overflow  = fix_flags ? fix_val : 1'($urandom);
      mem_ready = (d == 0) ? 1'($urandom) : q[i].last;
      if (i == rst_at) begin
        mem_ready = 1'b1;
        if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
        @(negedge clk);
        check_eq("rst_strobes", 64'(strobes(d)), 64'd0);
        check_eq("rst_mem_write", 64'(mem_write[d]), 64'd0);
        @(posedge clk);
        #1;
        if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
        cnt[d] = 0;
        return;
      end
      @(negedge clk);

      es = '0; enpc = '0; edst = '0; esrc = '0;
      case (q[i].st)
        0: begin
          es[5] = 1'b1;
          if (q[i].last) begin es[3] = 1'b1; es[2] = 1'b1; enpc = 2'd0; end
        end
        1: begin
          if (c == CJ || c == CJal) begin es[2] = 1'b1; enpc = 2'd2; end
          if (c == CJr) begin es[2] = 1'b1; enpc = 2'd3; end
          if (c == CJal) begin es[1] = 1'b1; edst = 2'd2; esrc = 3'd2; end
          if (c == CIll) es[0] = 1'b1;
        end
        2: begin
          ovf_s = overflow;
          if ((c == CBeq && zero) || (c == CBgtz && positive)) begin
            es[2] = 1'b1;
            enpc  = 2'd1;
          end
          if (c <= CSw) begin
            case (c)
              CAddu:    check_eq("alu_ctl", 64'(alu_ctl[d]), 64'd0);
              CSubu:    check_eq("alu_ctl", 64'(alu_ctl[d]), 64'd1);
              COri:     check_eq("alu_ctl", 64'(alu_ctl[d]), 64'd2);
              CLui:     check_eq("alu_ctl", 64'(alu_ctl[d]), 64'd3);
              default:  check_eq("alu_ctl", 64'(alu_ctl[d]), 64'd0);
            endcase
            check_eq("alu_src", 64'(alu_src[d]), (c == CAddu || c == CSubu) ? 64'd0 : 64'd1);
            if (c == CAddi || c == CLw || c == CSw) check_eq("ext_op", 64'(ext_op[d]), 64'd1);
            if (c == COri) check_eq("ext_op", 64'(ext_op[d]), 64'd0);
          end
        end
        3: begin
          es[5] = 1'b1;
          es[4] = (c == CSw);
        end
        default: begin
          es[1] = !(c == CAddi && ovf_s);
          edst  = (c == CAddu || c == CSubu) ? 2'd1 : 2'd0;
          esrc  = (c == CLw) ? 3'd1 : 3'd0;
        end
      endcase

      check_eq("state", 64'(state[d]), 64'(q[i].st));
      check_eq("strobes", 64'(strobes(d)), 64'(es));
      if (es[5]) check_eq("iord", 64'(mem_iord[d]), (q[i].st == 3) ? 64'd1 : 64'd0);
      if (es[2]) check_eq("npc_sel", 64'(npc_sel[d]), 64'(enpc));
      if (es[1]) check_eq("reg_sel", 64'({reg_dst[d], reg_src[d]}), 64'({edst, esrc}));
      check_eq("idle_strobes", 64'(strobes(1 - d)), 64'd0);
      if (i == 0) begin
        check_eq("instret", 64'(instret_of(d)),
                 (d == 0) ? 64'(cnt[0] % 16) : 64'(cnt[1]));
      end
      @(posedge clk);
      #1;
    end
    if (c != CIll) cnt[d]++;
  endtask

  task automatic run_rand(input int d);
    logic [5:0] op, fn;
    int sel;
    sel = $urandom_range(0, 13);
    fn  = 6'($urandom);
    case (sel)
      0:  begin op = 6'h00; fn = 6'h21; end
      1:  begin op = 6'h00; fn = 6'h23; end
      2:  begin op = 6'h00; fn = 6'h08; end
      3:  op = 6'h08;
      4:  op = 6'h0D;
      5:  op = 6'h0F;
      6:  op = 6'h23;
      7:  op = 6'h2B;
      8:  op = 6'h04;
      9:  op = 6'h07;
      10: op = 6'h02;
      11: op = 6'h03;
      12: begin
        op = 6'($urandom);
        while (classify(op, 6'h21) != CIll) op = 6'($urandom);
      end
      default: begin op = 6'h00; fn = 6'h3F; end
    endcase
    if (d == 0) run_insn(0, op, fn, 0, 0, -1);
    else run_insn(1, op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    opcode = '0; funct = '0;
    zero = 1'b0; positive = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
    cnt[0] = 0; cnt[1] = 0;

    // Reset held for three cycles on both instances.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_eq("reset_strobes", 64'(strobes(d)), 64'd0);
        check_eq("reset_state", 64'(state[d]), 64'd0);
        check_eq("reset_instret", 64'(instret_of(d)), 64'd0);
      end
    end
    @(posedge clk);
    #1;
    rst0 = 1'b0;

    // d0: no wait states.
    run_insn(0, 6'h00, 6'h21, 0, 0, -1);   // addu
    run_insn(0, 6'h23, 6'h00, 0, 0, -1);   // lw
    fix_flags = 1'b1; fix_val = 1'b1;
    run_insn(0, 6'h04, 6'h00, 0, 0, -1);   // beq taken
    run_insn(0, 6'h08, 6'h00, 0, 0, -1);   // addi with overflow
    fix_val = 1'b0;
    run_insn(0, 6'h04, 6'h00, 0, 0, -1);   // beq not taken
    fix_flags = 1'b0;
    run_insn(0, 6'h03, 6'h00, 0, 0, -1);   // jal
    run_insn(0, 6'h3F, 6'h00, 0, 0, -1);   // illegal
    for (int k = 0; k < 40; k++) run_rand(0);

    // d1: memory wait states.
    rst0 = 1'b1;
    rst1 = 1'b0;
    run_insn(1, 6'h23, 6'h00, 0, 3, -1);   // lw, three MEM wait cycles
    run_insn(1, 6'h2B, 6'h00, 1, 2, -1);   // sw
    run_insn(1, 6'h2B, 6'h00, 0, 0, 3);    // sw, reset in MEM
    run_insn(1, 6'h0D, 6'h00, 0, 0, -1);   // ori after reset restart
    for (int k = 0; k < 40; k++) run_rand(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
